// File: rtl/fpu_cvt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_cvt_pkg
//  Description : Shared types and constants for the binary32 -> integer
//                converter: rounding-mode enum, exception flag struct and
//                the payload carried from the align phase to the round phase.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_cvt_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_MANT_W = 23;
  localparam int F32_EXP_W  = 8;
  // Widest supported integer result; the payload magnitude is sized for it.
  localparam int MAG_MAX_W  = 64;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic nv;
    logic nx;
  } cvt_flags_t;

  // Align-phase result: truncated magnitude plus guard/sticky and the
  // per-beat controls that must travel with the data.
  typedef struct packed {
    logic                 sign;
    logic                 is_nan;
    logic                 ovf;     // Inf or |x| >= 2^OUT_W
    logic [MAG_MAX_W-1:0] mag;
    logic                 guard;
    logic                 sticky;
    rm_e                  rm;
    logic                 uns;
  } cvt_s1_t;

  // Reserved encodings 101..111 fall back to round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] raw);
    case (raw)
      3'b001:  return RTZ;
      3'b010:  return RDN;
      3'b011:  return RUP;
      3'b100:  return RMM;
      default: return RNE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp2i_round_core.sv
`default_nettype none
// ============================================================================
//  Module      : fp2i_round_core
//  Description : Combinational round / negate / saturate phase of the
//                binary32 -> integer converter. Produces the OUT_W-bit
//                result and NV/NX flags from the aligned payload.
//  Ports       : s1_pl  in   aligned payload (magnitude, guard, sticky, mode)
//                y      out  integer result
//                flags  out  {nv, nx}
//  Revision    : 1.0 - initial release
// ============================================================================
module fp2i_round_core
  import fpu_cvt_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  cvt_s1_t          s1_pl,
  output logic [OUT_W-1:0] y,
  output cvt_flags_t       flags
);

  localparam logic [OUT_W-1:0] c_SMAX    = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_SMIN    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] c_UMAX    = {OUT_W{1'b1}};
  localparam logic [OUT_W:0]   c_POS_LIM = {1'b0, c_SMAX};
  localparam logic [OUT_W:0]   c_NEG_LIM = {1'b0, c_SMIN};

  logic           w_inexact;
  logic           w_inc;
  logic           w_mag_hi;
  logic [OUT_W:0] w_mag_r;   // one extra bit catches the rounding carry

  assign w_inexact = s1_pl.guard | s1_pl.sticky;
  // Any magnitude bit above OUT_W means the value cannot fit at all.
  assign w_mag_hi  = |(s1_pl.mag >> OUT_W);

  always_comb begin
    w_inc = 1'b0;
    case (s1_pl.rm)
      RTZ:     w_inc = 1'b0;
      RDN:     w_inc = s1_pl.sign & w_inexact;
      RUP:     w_inc = ~s1_pl.sign & w_inexact;
      RMM:     w_inc = s1_pl.guard;
      default: w_inc = s1_pl.guard & (s1_pl.sticky | s1_pl.mag[0]);
    endcase
  end

  assign w_mag_r = {1'b0, s1_pl.mag[OUT_W-1:0]} + {{OUT_W{1'b0}}, w_inc};

  always_comb begin
    y     = '0;
    flags = '0;
    if (s1_pl.is_nan) begin
      y        = s1_pl.uns ? c_UMAX : c_SMAX;
      flags.nv = 1'b1;
    end else if (s1_pl.ovf | w_mag_hi) begin
      if (s1_pl.sign) y = s1_pl.uns ? '0 : c_SMIN;
      else            y = s1_pl.uns ? c_UMAX : c_SMAX;
      flags.nv = 1'b1;
    end else if (!s1_pl.sign) begin
      if (s1_pl.uns ? w_mag_r[OUT_W] : (w_mag_r > c_POS_LIM)) begin
        y        = s1_pl.uns ? c_UMAX : c_SMAX;
        flags.nv = 1'b1;
      end else begin
        y        = w_mag_r[OUT_W-1:0];
        flags.nx = w_inexact;
      end
    end else if (s1_pl.uns) begin
      // Negative into unsigned: only a value rounding to zero is legal.
      if (w_mag_r == '0) flags.nx = w_inexact;
      else               flags.nv = 1'b1;
    end else begin
      // Exactly 2^(OUT_W-1) negates to the signed minimum without NV.
      if (w_mag_r > c_NEG_LIM) begin
        y        = c_SMIN;
        flags.nv = 1'b1;
      end else begin
        y        = -w_mag_r[OUT_W-1:0];
        flags.nx = w_inexact;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp32_to_int_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_to_int_pipe
//  Description : Pipelined IEEE-754 binary32 -> OUT_W-bit integer converter
//                with run-time rounding mode, signed/unsigned select,
//                saturation with NV/NX flags and valid/ready flow control.
//                Holds the classify/align phase, the stage registers and
//                the handshake; rounding lives in fp2i_round_core.
//  Config      : FTOI_SUBNORM_DAZ_EN - when defined, subnormal inputs are
//                treated as exact zero (result 0, no flags).
//  Ports       : sys_clk, rstn (sync, active-low)
//                in_valid/in_ready, in_x, in_rm, in_unsigned   - input beat
//                out_valid/out_ready, out_y, out_nv, out_nx    - result beat
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_to_int_pipe
  import fpu_cvt_pkg::*;
#(
  parameter int OUT_W       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [2:0]       in_rm,
  input  logic             in_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             out_nv,
  output logic             out_nx
);

  localparam logic [7:0] c_SHIFT_BASE = 8'(F32_BIAS + OUT_W - 1);
  localparam logic [7:0] c_HUGE_E     = 8'(F32_BIAS + OUT_W);
  localparam logic [7:0] c_TINY_E     = 8'(F32_BIAS - 1);
  localparam int         c_ALIGN_W    = OUT_W + F32_MANT_W + 1;

  // ---------------------------------------------------------------- S1
  logic                  w_sign;
  logic [F32_EXP_W-1:0]  w_exp;
  logic [F32_MANT_W-1:0] w_frac;
  logic [7:0]            w_shift;
  logic [c_ALIGN_W-1:0]  w_align;
  cvt_s1_t               w_s1_pl;

  assign w_sign  = in_x[31];
  assign w_exp   = in_x[F32_MANT_W +: F32_EXP_W];
  assign w_frac  = in_x[F32_MANT_W-1:0];
  assign w_shift = c_SHIFT_BASE - w_exp;
  // Hidden-bit mantissa placed with its MSB at integer bit OUT_W-1 and
  // F32_MANT_W+1 fraction bits below; shifts never exceed OUT_W here, so
  // no mantissa bit falls off the bottom.
  assign w_align = {1'b1, w_frac, {OUT_W{1'b0}}} >> w_shift;

  always_comb begin
    w_s1_pl      = '0;
    w_s1_pl.sign = w_sign;
    w_s1_pl.rm   = decode_rm(in_rm);
    w_s1_pl.uns  = in_unsigned;
    if (w_exp == 8'hFF) begin
      w_s1_pl.is_nan = |w_frac;
      w_s1_pl.ovf    = ~|w_frac;
    end else if (w_exp == 8'h00) begin
`ifdef FTOI_SUBNORM_DAZ_EN
      w_s1_pl.sticky = 1'b0;
`else
      // Nonzero subnormal: below one half, visible only through sticky.
      w_s1_pl.sticky = |w_frac;
`endif
    end else if (w_exp >= c_HUGE_E) begin
      w_s1_pl.ovf = 1'b1;
    end else if (w_exp < c_TINY_E) begin
      w_s1_pl.sticky = 1'b1;  // 0 < |x| < 0.5
    end else begin
      w_s1_pl.mag    = MAG_MAX_W'(w_align[c_ALIGN_W-1 -: OUT_W]);
      w_s1_pl.guard  = w_align[F32_MANT_W];
      w_s1_pl.sticky = |w_align[F32_MANT_W-1:0];
    end
  end

  // ---------------------------------------------------- pipeline control
  logic             r_rdy_en;   // holds in_ready low during the reset cycle
  logic             w_in_valid;
  logic             w_b_in_valid;
  cvt_s1_t          w_b_pl;
  logic             w_b_load;
  logic             w_c_load;
  logic             r_b_valid;
  logic [OUT_W-1:0] r_b_y;
  cvt_flags_t       r_b_flags;
  logic [OUT_W-1:0] w_rc_y;
  cvt_flags_t       w_rc_flags;

  always_ff @(posedge sys_clk) begin
    if (!rstn) r_rdy_en <= 1'b0;
    else       r_rdy_en <= 1'b1;
  end

  assign w_in_valid = in_valid & r_rdy_en;

  generate
    if (PIPE_STAGES >= 2) begin : g_s1_reg
      logic    r_a_valid;
      cvt_s1_t r_a_pl;
      logic    w_a_load;

      assign w_a_load = ~r_a_valid | w_b_load;

      always_ff @(posedge sys_clk) begin
        if (!rstn) begin
          r_a_valid <= 1'b0;
          r_a_pl    <= '0;
        end else if (w_a_load) begin
          r_a_valid <= w_in_valid;
          if (w_in_valid) r_a_pl <= w_s1_pl;
        end
      end

      assign w_b_in_valid = r_a_valid;
      assign w_b_pl       = r_a_pl;
      assign in_ready     = w_a_load & r_rdy_en;
    end else begin : g_s1_comb
      assign w_b_in_valid = w_in_valid;
      assign w_b_pl       = w_s1_pl;
      assign in_ready     = w_b_load & r_rdy_en;
    end
  endgenerate

  // ---------------------------------------------------------------- S2
  fp2i_round_core #(
    .OUT_W (OUT_W)
  ) u_round_core (
    .s1_pl (w_b_pl),
    .y     (w_rc_y),
    .flags (w_rc_flags)
  );

  assign w_b_load = ~r_b_valid | w_c_load;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_b_valid <= 1'b0;
      r_b_y     <= '0;
      r_b_flags <= '0;
    end else if (w_b_load) begin
      r_b_valid <= w_b_in_valid;
      if (w_b_in_valid) begin
        r_b_y     <= w_rc_y;
        r_b_flags <= w_rc_flags;
      end
    end
  end

  generate
    if (PIPE_STAGES >= 3) begin : g_out_reg
      logic             r_c_valid;
      logic [OUT_W-1:0] r_c_y;
      cvt_flags_t       r_c_flags;

      assign w_c_load = ~r_c_valid | out_ready;

      always_ff @(posedge sys_clk) begin
        if (!rstn) begin
          r_c_valid <= 1'b0;
          r_c_y     <= '0;
          r_c_flags <= '0;
        end else if (w_c_load) begin
          r_c_valid <= r_b_valid;
          if (r_b_valid) begin
            r_c_y     <= r_b_y;
            r_c_flags <= r_b_flags;
          end
        end
      end

      assign out_valid = r_c_valid;
      assign out_y     = r_c_y;
      assign out_nv    = r_c_flags.nv;
      assign out_nx    = r_c_flags.nx;
    end else begin : g_out_direct
      assign w_c_load  = out_ready;
      assign out_valid = r_b_valid;
      assign out_y     = r_b_y;
      assign out_nv    = r_b_flags.nv;
      assign out_nx    = r_b_flags.nx;
    end
  endgenerate

endmodule
`default_nettype wire
